// File: rtl/debounce_event_ctrl.sv
// Multi-channel debouncer with edge / long-press detection. Detected events
// are queued per channel as pending flags, then serialised into a ready/valid FIFO.
module debounce_event_ctrl #(
    parameter int              WIDTH      = 9,
    parameter int              N          = 4,
    parameter int              RATE       = 250000,
    parameter int              LONG_TICKS = 250,
    parameter logic [WIDTH-1:0] INVERT    = {WIDTH{1'b0}},
    parameter int              DEPTH      = 8,
    localparam int             CW         = (WIDTH > 1) ? $clog2(WIDTH) : 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] in,
    output logic [WIDTH-1:0] out,
    output logic [WIDTH-1:0] rise,
    output logic [WIDTH-1:0] fall,
    output logic [WIDTH-1:0] long,
    output logic             m_ev_valid,
    input  logic             m_ev_ready,
    output logic [CW-1:0]    m_ev_chan,
    output logic [1:0]       m_ev_type,
    output logic             ev_overflow,
    input  logic             ev_overflow_clr
);

    localparam int PW  = $clog2(RATE);
    localparam int LCW = (LONG_TICKS < 2) ? 1 : $clog2(LONG_TICKS + 1);
    localparam int AW  = $clog2(DEPTH);
    localparam int EW  = CW + 2;

    localparam logic [PW-1:0]  PRESC_LAST = PW'(RATE - 1);
    localparam logic [PW-1:0]  PRESC_ONE  = PW'(1);
    localparam logic [LCW-1:0] LONG_MAX   = LCW'(LONG_TICKS);
    localparam logic [LCW-1:0] LONG_ONE   = LCW'(1);
    localparam logic [AW:0]    PTR_ONE    = (AW + 1)'(1);

    localparam logic [1:0] EV_RISE = 2'b01;
    localparam logic [1:0] EV_FALL = 2'b10;
    localparam logic [1:0] EV_LONG = 2'b11;

    // Input synchroniser
    logic [WIDTH-1:0] sync1_q;
    logic [WIDTH-1:0] sync2_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_q <= '0;
            sync2_q <= '0;
        end else begin
            sync1_q <= in ^ INVERT;
            sync2_q <= sync1_q;
        end
    end

    // Sample-rate prescaler
    logic [PW-1:0] presc_q;
    logic [PW-1:0] presc_d;
    logic          tick;

    always_comb begin
        tick    = (presc_q == PRESC_LAST);
        presc_d = tick ? '0 : presc_q + PRESC_ONE;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            presc_q <= '0;
        end else begin
            presc_q <= presc_d;
        end
    end

    // Debounce history, level, edge pulses and long-press counters
    logic [N-1:0]     hist_q [WIDTH];
    logic [N-1:0]     hist_d [WIDTH];
    logic [LCW-1:0]   lcnt_q [WIDTH];
    logic [LCW-1:0]   lcnt_d [WIDTH];
    logic [WIDTH-1:0] out_q,  out_d;
    logic [WIDTH-1:0] rise_q, rise_d;
    logic [WIDTH-1:0] fall_q, fall_d;
    logic [WIDTH-1:0] long_q, long_d;

    always_comb begin
        hist_d = hist_q;
        lcnt_d = lcnt_q;
        out_d  = out_q;
        rise_d = '0;
        fall_d = '0;
        long_d = '0;
        for (int i = 0; i < WIDTH; i++) begin
            if (tick) begin
                hist_d[i] = {hist_q[i][N-2:0], sync2_q[i]};
                if (&hist_d[i]) begin
                    out_d[i] = 1'b1;
                end else if (~|hist_d[i]) begin
                    out_d[i] = 1'b0;
                end
            end
            rise_d[i] = out_d[i] & ~out_q[i];
            fall_d[i] = ~out_d[i] & out_q[i];
            // Counter saturates at LONG_MAX so the pulse fires only once per press;
            // with LONG_TICKS = 0 it never leaves zero and long stays quiet.
            if (!out_q[i]) begin
                lcnt_d[i] = '0;
            end else if (tick && (lcnt_q[i] != LONG_MAX)) begin
                lcnt_d[i] = lcnt_q[i] + LONG_ONE;
                long_d[i] = (lcnt_d[i] == LONG_MAX);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < WIDTH; i++) begin
                hist_q[i] <= '0;
                lcnt_q[i] <= '0;
            end
            out_q  <= '0;
            rise_q <= '0;
            fall_q <= '0;
            long_q <= '0;
        end else begin
            hist_q <= hist_d;
            lcnt_q <= lcnt_d;
            out_q  <= out_d;
            rise_q <= rise_d;
            fall_q <= fall_d;
            long_q <= long_d;
        end
    end

    // Pending flags and serialiser
    logic [WIDTH-1:0] pr_q, pr_d;
    logic [WIDTH-1:0] pl_q, pl_d;
    logic [WIDTH-1:0] pf_q, pf_d;
    logic [WIDTH-1:0] sel_r, sel_l, sel_f;
    logic [WIDTH-1:0] clr_r, clr_l, clr_f;
    logic             sel_found;
    logic [CW-1:0]    sel_chan;
    logic [1:0]       sel_type;
    logic             push;
    logic             pop;
    logic             fifo_full;
    logic             fifo_empty;
    logic             ovf_set;
    logic             ovf_q, ovf_d;

    always_comb begin
        sel_found = 1'b0;
        sel_chan  = '0;
        sel_type  = '0;
        sel_r     = '0;
        sel_l     = '0;
        sel_f     = '0;
        for (int i = 0; i < WIDTH; i++) begin
            if (!sel_found && (pr_q[i] || pl_q[i] || pf_q[i])) begin
                sel_found = 1'b1;
                sel_chan  = CW'(i);
                if (pr_q[i]) begin
                    sel_type = EV_RISE;
                    sel_r[i] = 1'b1;
                end else if (pl_q[i]) begin
                    sel_type = EV_LONG;
                    sel_l[i] = 1'b1;
                end else begin
                    sel_type = EV_FALL;
                    sel_f[i] = 1'b1;
                end
            end
        end
    end

    always_comb begin
        push  = sel_found && !fifo_full;
        clr_r = push ? sel_r : '0;
        clr_l = push ? sel_l : '0;
        clr_f = push ? sel_f : '0;
        // A pulse landing on a flag that is being pushed this cycle just re-arms it.
        pr_d  = (pr_q & ~clr_r) | rise_q;
        pl_d  = (pl_q & ~clr_l) | long_q;
        pf_d  = (pf_q & ~clr_f) | fall_q;
        ovf_set = |((pr_q & ~clr_r & rise_q) |
                    (pl_q & ~clr_l & long_q) |
                    (pf_q & ~clr_f & fall_q));
        if (ovf_set) begin
            ovf_d = 1'b1;
        end else if (ev_overflow_clr) begin
            ovf_d = 1'b0;
        end else begin
            ovf_d = ovf_q;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pr_q  <= '0;
            pl_q  <= '0;
            pf_q  <= '0;
            ovf_q <= 1'b0;
        end else begin
            pr_q  <= pr_d;
            pl_q  <= pl_d;
            pf_q  <= pf_d;
            ovf_q <= ovf_d;
        end
    end

    // Show-ahead event FIFO; pointers carry a wrap bit to tell full from empty
    logic [EW-1:0] mem_q [DEPTH];
    logic [AW:0]   wptr_q;
    logic [AW:0]   rptr_q;

    always_comb begin
        fifo_empty = (wptr_q == rptr_q);
        fifo_full  = (wptr_q[AW] != rptr_q[AW]) &&
                     (wptr_q[AW-1:0] == rptr_q[AW-1:0]);
        pop        = !fifo_empty && m_ev_ready;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            wptr_q <= '0;
            rptr_q <= '0;
        end else begin
            if (push) begin
                mem_q[wptr_q[AW-1:0]] <= {sel_chan, sel_type};
                wptr_q <= wptr_q + PTR_ONE;
            end
            if (pop) begin
                rptr_q <= rptr_q + PTR_ONE;
            end
        end
    end

    assign out         = out_q;
    assign rise        = rise_q;
    assign fall        = fall_q;
    assign long        = long_q;
    assign ev_overflow = ovf_q;
    assign m_ev_valid  = !fifo_empty;
    assign {m_ev_chan, m_ev_type} = fifo_empty ? '0 : mem_q[rptr_q[AW-1:0]];

endmodule

// File: tb/tb_debounce_event_ctrl.sv
// Scoreboard bench for debounce_event_ctrl: stimulus queues expected events,
// a negedge monitor pops and compares every accepted stream beat.
module tb_debounce_event_ctrl;

    localparam int WIDTH = 9;
    localparam int N     = 4;
    localparam int RATE  = 4;
    localparam int LT    = 8;
    localparam int DEPTH = 2;
    localparam int CW    = 4;

    localparam logic [1:0] T_R = 2'b01;
    localparam logic [1:0] T_F = 2'b10;
    localparam logic [1:0] T_L = 2'b11;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic [WIDTH-1:0] in_v = '0;
    logic [WIDTH-1:0] out_v, rise_v, fall_v, long_v;
    logic             m_ev_valid;
    logic             m_ev_ready = 1'b0;
    logic [CW-1:0]    m_ev_chan;
    logic [1:0]       m_ev_type;
    logic             ev_overflow;
    logic             ev_overflow_clr = 1'b0;

    debounce_event_ctrl #(
        .WIDTH(WIDTH), .N(N), .RATE(RATE), .LONG_TICKS(LT),
        .INVERT(9'b0), .DEPTH(DEPTH)
    ) dut (
        .clk(clk), .rst_n(rst_n), .in(in_v),
        .out(out_v), .rise(rise_v), .fall(fall_v), .long(long_v),
        .m_ev_valid(m_ev_valid), .m_ev_ready(m_ev_ready),
        .m_ev_chan(m_ev_chan), .m_ev_type(m_ev_type),
        .ev_overflow(ev_overflow), .ev_overflow_clr(ev_overflow_clr)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int prev_pop = 0, last_pop = 0;
    int t_rise2 = 0, t_long2 = 0;
    logic [CW+1:0] exp_q[$];

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin : monitor
        logic [CW+1:0] e;
        if (rst_n && m_ev_valid && m_ev_ready) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL stream_unexpected: got chan %0d type %b, nothing expected",
                         m_ev_chan, m_ev_type);
            end else begin
                e = exp_q.pop_front();
                if ({m_ev_chan, m_ev_type} !== e) begin
                    errors++;
                    $display("FAIL stream_event: got chan %0d type %b, expected chan %0d type %b",
                             m_ev_chan, m_ev_type, e[CW+1:2], e[1:0]);
                end
            end
            prev_pop = last_pop;
            last_pop = cyc;
            if (m_ev_chan == 4'd2 && m_ev_type == T_R) t_rise2 = cyc;
            if (m_ev_chan == 4'd2 && m_ev_type == T_L) t_long2 = cyc;
        end
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    task automatic expect_ev(input int chan, input logic [1:0] typ);
        exp_q.push_back({CW'(chan), typ});
    endtask

    task automatic wait_drain(input string name, input int bound);
        int i = 0;
        while (exp_q.size() != 0 && i < bound) begin
            step(1);
            i++;
        end
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL drain_%s: %0d events still outstanding after %0d cycles, expected 0",
                     name, exp_q.size(), bound);
            exp_q.delete();
        end
    endtask

    initial begin
        int first_out, rc, fc, lc, bad, vc;

        rst_n = 1'b0;
        step(3);
        rst_n = 1'b1;
        step(1);
        check("reset_out", out_v, 0);
        check("reset_valid", m_ev_valid, 0);
        check("reset_overflow", ev_overflow, 0);

        // Single short press on channel 0
        m_ev_ready = 1'b1;
        expect_ev(0, T_R);
        expect_ev(0, T_F);
        first_out = -1; rc = 0; fc = 0; lc = 0;
        in_v[0] = 1'b1;
        for (int i = 1; i <= 24; i++) begin
            step(1);
            if (out_v[0] && first_out < 0) first_out = i;
            rc += int'(rise_v[0]); fc += int'(fall_v[0]); lc += int'(long_v[0]);
        end
        in_v[0] = 1'b0;
        for (int i = 0; i < 30; i++) begin
            step(1);
            rc += int'(rise_v[0]); fc += int'(fall_v[0]); lc += int'(long_v[0]);
        end
        check("press_out_latency_le_19", (first_out >= 1 && first_out <= 19), 1);
        check("press_rise_pulses", rc, 1);
        check("press_fall_pulses", fc, 1);
        check("press_long_pulses", lc, 0);
        check("press_out_released", out_v[0], 0);
        wait_drain("press", 20);

        // Glitch rejection on channel 3
        bad = 0; vc = 0;
        in_v[3] = 1'b1;
        for (int i = 0; i < 4; i++) begin step(1); bad += int'((out_v | rise_v | fall_v) != 0); vc += int'(m_ev_valid); end
        in_v[3] = 1'b0;
        for (int i = 0; i < 20; i++) begin step(1); bad += int'((out_v | rise_v | fall_v) != 0); vc += int'(m_ev_valid); end
        for (int k = 0; k < 6; k++) begin
            in_v[3] = ~in_v[3];
            for (int i = 0; i < 8; i++) begin step(1); bad += int'((out_v | rise_v | fall_v) != 0); vc += int'(m_ev_valid); end
        end
        in_v[3] = 1'b0;
        for (int i = 0; i < 30; i++) begin step(1); bad += int'((out_v | rise_v | fall_v) != 0); vc += int'(m_ev_valid); end
        check("glitch_level_activity", bad, 0);
        check("glitch_valid_cycles", vc, 0);

        // Long press on channel 2, twice
        for (int rep = 0; rep < 2; rep++) begin
            expect_ev(2, T_R);
            expect_ev(2, T_L);
            expect_ev(2, T_F);
            lc = 0;
            in_v[2] = 1'b1;
            for (int i = 0; i < 80; i++) begin step(1); lc += int'(long_v[2]); end
            in_v[2] = 1'b0;
            for (int i = 0; i < 30; i++) begin step(1); lc += int'(long_v[2]); end
            wait_drain("long", 20);
            check("long_pulses_per_press", lc, 1);
            check("long_delay_cycles", t_long2 - t_rise2, LT * RATE);
        end

        // Simultaneous rise on channels 5 and 1
        expect_ev(1, T_R);
        expect_ev(5, T_R);
        in_v[1] = 1'b1;
        in_v[5] = 1'b1;
        step(24);
        wait_drain("simul_rise", 20);
        check("simul_rise_gap", last_pop - prev_pop, 1);
        expect_ev(1, T_F);
        expect_ev(5, T_F);
        in_v[1] = 1'b0;
        in_v[5] = 1'b0;
        step(30);
        wait_drain("simul_fall", 20);
        check("simul_fall_gap", last_pop - prev_pop, 1);

        // Backpressure: three channels toggled twice with the consumer stalled
        m_ev_ready = 1'b0;
        expect_ev(6, T_R); expect_ev(7, T_R);
        expect_ev(6, T_R); expect_ev(6, T_F);
        expect_ev(7, T_R); expect_ev(7, T_F);
        expect_ev(8, T_R); expect_ev(8, T_F);
        in_v[8:6] = 3'b111;
        step(24);
        in_v[8:6] = 3'b000;
        step(24);
        check("bp_overflow_after_first_toggle", ev_overflow, 0);
        in_v[8:6] = 3'b111;
        step(24);
        in_v[8:6] = 3'b000;
        step(30);
        check("bp_overflow_after_second_toggle", ev_overflow, 1);
        check("bp_valid_held", m_ev_valid, 1);
        check("bp_head_stable", {m_ev_chan, m_ev_type}, {4'd6, T_R});
        m_ev_ready = 1'b1;
        wait_drain("backpressure", 40);
        check("bp_overflow_sticky", ev_overflow, 1);
        ev_overflow_clr = 1'b1;
        step(1);
        ev_overflow_clr = 1'b0;
        step(1);
        check("bp_overflow_cleared", ev_overflow, 0);

        // Reset while events are queued
        m_ev_ready = 1'b0;
        expect_ev(0, T_R);
        expect_ev(4, T_R);
        in_v[0] = 1'b1;
        in_v[4] = 1'b1;
        step(24);
        check("pre_reset_levels", {out_v[4], out_v[0], m_ev_valid}, 3'b111);
        #1;
        rst_n = 1'b0;
        #1;
        check("reset_async_outputs",
              {out_v, rise_v, fall_v, long_v, m_ev_valid, m_ev_chan, m_ev_type, ev_overflow}, 0);
        exp_q.delete();
        in_v = '0;
        step(3);
        rst_n = 1'b1;
        m_ev_ready = 1'b1;
        vc = 0;
        for (int i = 0; i < 80; i++) begin step(1); vc += int'(m_ev_valid); end
        check("post_reset_no_stale_events", vc, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
